// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: run-time selectable PRBS7/9/15/23/31 generator and
// self-synchronising bit-error checker. Optional macro: PRBS_ERR_INJ_EN.
module prbs_gen_chk #(
    parameter int W          = 8,
    parameter int CNT_W      = 16,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             seed_load,
    input  logic [30:0]      seed,
    input  logic             inj_err,
    output logic [W-1:0]     gen_data,
    output logic             gen_valid,
    input  logic [W-1:0]     chk_data,
    input  logic             chk_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } st_t;

    logic [2:0]       mode_q, mode_d, mode_eff;
    logic             mode_chg;
    logic [4:0]       ti1, ti2;
    logic [30:0]      mask;

    logic [30:0]      s_q, s_d, s_adv, seed_m;
    logic [W-1:0]     gbits, inj_w;
    logic [W-1:0]     gdata_q, gdata_d;
    logic             gvalid_q, gvalid_d;

    logic [30:0]      h_q, h_d, h_w;
    logic [W-1:0]     mm;
    logic [5:0]       pc;
    st_t              st_q, st_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W+5:0] sum;

    always_comb begin : mode_sel
        mode_eff = (mode > 3'd4) ? 3'd0 : mode;
        mode_chg = (mode_eff != mode_q);
    end

    // Tap indices are (tap - 1); mask keeps only the active n bits.
    always_comb begin : tap_dec
        ti1  = 5'd6;
        ti2  = 5'd5;
        mask = 31'h0000_007F;
        unique case (mode_q)
            3'd1: begin
                ti1  = 5'd8;
                ti2  = 5'd4;
                mask = 31'h0000_01FF;
            end
            3'd2: begin
                ti1  = 5'd14;
                ti2  = 5'd13;
                mask = 31'h0000_7FFF;
            end
            3'd3: begin
                ti1  = 5'd22;
                ti2  = 5'd17;
                mask = 31'h007F_FFFF;
            end
            3'd4: begin
                ti1  = 5'd30;
                ti2  = 5'd27;
                mask = 31'h7FFF_FFFF;
            end
            default: begin
                ti1  = 5'd6;
                ti2  = 5'd5;
                mask = 31'h0000_007F;
            end
        endcase
    end

    always_comb begin : gen_step
        s_adv = s_q;
        gbits = '0;
        for (int i = 0; i < W; i++) begin
            gbits[i] = s_adv[ti1] ^ s_adv[ti2];
            s_adv    = {s_adv[29:0], gbits[i]} & mask;
        end
    end

`ifdef PRBS_ERR_INJ_EN
    always_comb begin : inj_sel
        inj_w    = '0;
        inj_w[0] = inj_err;
    end
`else
    logic unused_inj;
    assign unused_inj = inj_err;
    assign inj_w      = '0;
`endif

    always_comb begin : gen_next
        seed_m   = seed & mask;
        s_d      = s_q;
        mode_d   = mode_q;
        gdata_d  = gdata_q;
        gvalid_d = 1'b0;
        if (mode_chg) begin
            s_d    = 31'd1;
            mode_d = mode_eff;
        end else if (seed_load) begin
            s_d = (seed_m == '0) ? 31'd1 : seed_m;
        end else if (en) begin
            s_d      = s_adv;
            gdata_d  = gbits ^ inj_w;
            gvalid_d = 1'b1;
        end
    end

    // Predict each bit from received history, so lock needs no seed.
    always_comb begin : chk_step
        h_w = h_q;
        mm  = '0;
        pc  = '0;
        for (int i = 0; i < W; i++) begin
            mm[i] = chk_data[i] ^ h_w[ti1] ^ h_w[ti2];
            h_w   = {h_w[29:0], chk_data[i]} & mask;
            pc    = pc + {5'd0, mm[i]};
        end
        h_d = chk_valid ? h_w : h_q;
    end

    always_comb begin : fsm_next
        st_d   = st_q;
        good_d = good_q;
        bad_d  = bad_q;
        if (mode_chg) begin
            st_d   = SEARCH;
            good_d = '0;
            bad_d  = '0;
        end else if (chk_valid) begin
            unique case (st_q)
                SEARCH: begin
                    if (mm == '0 && chk_data != '0) begin
                        if (good_q == GW'(LOCK_CNT - 1)) begin
                            st_d   = LOCKED;
                            good_d = '0;
                            bad_d  = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (mm != '0) begin
                        if (bad_q == BW'(UNLOCK_CNT - 1)) begin
                            st_d   = SEARCH;
                            bad_d  = '0;
                            good_d = '0;
                        end else begin
                            bad_d = bad_q + BW'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin : err_next
        sum   = (CNT_W + 6)'(err_q) + (CNT_W + 6)'(pc);
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (chk_valid && !mode_chg && st_q == LOCKED) begin
            err_d = (|sum[CNT_W+5:CNT_W]) ? '1 : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin : regs
        if (rst_n) begin
            s_q      <= 31'd1;
            mode_q   <= 3'd0;
            gdata_q  <= '0;
            gvalid_q <= 1'b0;
            h_q      <= '0;
            st_q     <= SEARCH;
            good_q   <= '0;
            bad_q    <= '0;
            err_q    <= '0;
        end else begin
            s_q      <= s_d;
            mode_q   <= mode_d;
            gdata_q  <= gdata_d;
            gvalid_q <= gvalid_d;
            h_q      <= h_d;
            st_q     <= st_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
        end
    end

    always_comb begin : outs
        locked    = (st_q == LOCKED);
        gen_data  = gdata_q;
        gen_valid = gvalid_q;
        err_cnt   = err_q;
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: scoreboard bench for prbs_gen_chk in loopback,
// with forced-error, saturation, clear and async-reset scenarios.
module tb_prbs_gen_chk;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [2:0]       mode;
    logic             seed_load;
    logic [30:0]      seed;
    logic             inj_err;
    logic [W-1:0]     gen_data;
    logic             gen_valid;
    logic [W-1:0]     chk_data;
    logic             chk_valid;
    logic             err_clr;
    logic             locked;
    logic [CNT_W-1:0] err_cnt;
    logic             force_ff = 1'b0;

    int               n_vec = 0;
    int               n_err = 0;
    logic [7:0]       sbq[$];
    logic [30:0]      ms = 31'd1;
    logic [2:0]       mq = 3'd0;
    logic [7:0]       last_w = 8'd0;

    prbs_gen_chk #(
        .W(W), .CNT_W(CNT_W), .LOCK_CNT(4), .UNLOCK_CNT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .seed_load(seed_load), .seed(seed), .inj_err(inj_err),
        .gen_data(gen_data), .gen_valid(gen_valid),
        .chk_data(chk_data), .chk_valid(chk_valid),
        .err_clr(err_clr), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    assign chk_data  = force_ff ? 8'hFF : gen_data;
    assign chk_valid = force_ff | gen_valid;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int plen(input logic [2:0] m);
        case (m)
            3'd1: return 9;
            3'd2: return 15;
            3'd3: return 23;
            3'd4: return 31;
            default: return 7;
        endcase
    endfunction

    function automatic int ptap(input logic [2:0] m);
        case (m)
            3'd1: return 5;
            3'd2: return 14;
            3'd3: return 18;
            3'd4: return 28;
            default: return 6;
        endcase
    endfunction

    // Drive one cycle of generator controls and advance the reference.
    task automatic cyc(input logic e, input logic [2:0] m, input logic sl,
                       input logic [30:0] sd, input logic ij);
        logic [2:0]  me;
        logic [31:0] msk;
        logic [7:0]  w;
        logic        nb;
        int          n, t;
        en        = e;
        mode      = m;
        seed_load = sl;
        seed      = sd;
        inj_err   = ij;
        me  = (m > 3'd4) ? 3'd0 : m;
        n   = plen(mq);
        t   = ptap(mq);
        msk = (32'h1 << n) - 32'h1;
        w   = 8'd0;
        if (me != mq) begin
            ms = 31'd1;
            mq = me;
        end else if (sl) begin
            ms = sd & msk[30:0];
            if (ms == 31'd0) ms = 31'd1;
        end else if (e) begin
            for (int i = 0; i < 8; i++) begin
                nb   = ms[n-1] ^ ms[t-1];
                w[i] = nb;
                ms   = ({ms[29:0], nb}) & msk[30:0];
            end
`ifdef PRBS_ERR_INJ_EN
            w[0] = w[0] ^ ij;
`endif
            sbq.push_back(w);
            last_w = w;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lock(input string tag, input logic [2:0] m);
        int k;
        k = 0;
        while (!locked && k < 24) begin
            cyc(1'b1, m, 1'b0, 31'd0, 1'b0);
            k++;
        end
        check(tag, 32'(locked), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst_n && gen_valid) begin
            check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0)
                check("gen_data", 32'(gen_data), 32'(sbq.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        en        = 1'b0;
        mode      = 3'd0;
        seed_load = 1'b0;
        seed      = 31'd0;
        inj_err   = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gen_valid", 32'(gen_valid), 32'd0);
        check("rst_gen_data", 32'(gen_data), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b0;

        cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        check("first_word", 32'(gen_data), 32'h60);
        check("first_valid", 32'(gen_valid), 32'd1);
        repeat (130) cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);

        cyc(1'b0, 3'd0, 1'b0, 31'd0, 1'b0);
        check("hold_valid", 32'(gen_valid), 32'd0);
        check("hold_data", 32'(gen_data), 32'(last_w));
        cyc(1'b0, 3'd0, 1'b0, 31'd0, 1'b0);
        check("hold_data2", 32'(gen_data), 32'(last_w));

        cyc(1'b0, 3'd0, 1'b1, 31'd0, 1'b0);
        check("seed_valid", 32'(gen_valid), 32'd0);
        cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        check("seed0_word", 32'(gen_data), 32'h60);

        for (int m = 0; m < 5; m++) begin
            cyc(1'b0, 3'(m), 1'b0, 31'd0, 1'b0);
            if (m != 0) begin
                check("mode_unlock", 32'(locked), 32'd0);
                check("mode_valid", 32'(gen_valid), 32'd0);
            end
            wait_lock($sformatf("lock_m%0d", m), 3'(m));
            err_clr = 1'b1;
            cyc(1'b1, 3'(m), 1'b0, 31'd0, 1'b0);
            err_clr = 1'b0;
            repeat (1000) cyc(1'b1, 3'(m), 1'b0, 31'd0, 1'b0);
            check($sformatf("hold_lock_m%0d", m), 32'(locked), 32'd1);
            check($sformatf("err0_m%0d", m), 32'(err_cnt), 32'd0);
        end

        cyc(1'b1, 3'd4, 1'b0, 31'd0, 1'b1);
        repeat (40) cyc(1'b1, 3'd4, 1'b0, 31'd0, 1'b0);
`ifdef PRBS_ERR_INJ_EN
        check("inj_err_cnt", 32'(err_cnt), 32'd3);
`else
        check("inj_err_cnt", 32'(err_cnt), 32'd0);
`endif
        check("inj_locked", 32'(locked), 32'd1);

        cyc(1'b0, 3'd0, 1'b0, 31'd0, 1'b0);
        wait_lock("lock_f", 3'd0);
        err_clr = 1'b1;
        cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        err_clr  = 1'b0;
        force_ff = 1'b1;
        repeat (3) cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        check("ff_locked3", 32'(locked), 32'd1);
        cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        check("ff_unlock4", 32'(locked), 32'd0);
        check("ff_sat", 32'(err_cnt), 32'd15);
        err_clr = 1'b1;
        cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        err_clr = 1'b0;
        check("ff_clr", 32'(err_cnt), 32'd0);

        force_ff = 1'b0;
        wait_lock("relock", 3'd0);
        check("relock_err0", 32'(err_cnt), 32'd0);
        force_ff = 1'b1;
        err_clr  = 1'b1;
        cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        force_ff = 1'b0;
        err_clr  = 1'b0;
        check("clr_prio", 32'(err_cnt), 32'd0);
        repeat (4) cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        force_ff = 1'b1;
        cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        force_ff = 1'b0;
        check("err_nonzero", 32'(err_cnt != '0), 32'd1);
        check("one_bad_locked", 32'(locked), 32'd1);

        rst_n = 1'b1;
        en    = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_err_cnt", 32'(err_cnt), 32'd0);
        check("arst_valid", 32'(gen_valid), 32'd0);
        check("arst_data", 32'(gen_data), 32'd0);
        sbq.delete();
        ms = 31'd1;
        mq = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        check("post_rst_word", 32'(gen_data), 32'h60);
        wait_lock("lock_after_rst", 3'd0);
        repeat (50) cyc(1'b1, 3'd0, 1'b0, 31'd0, 1'b0);
        en = 1'b0;
        check("post_rst_err0", 32'(err_cnt), 32'd0);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised PRBS generator and self-synchronising checker: the next generation of the team's fixed 8-bit PRBS7 shifter. Selects PRBS7/9/15/23/31 at run time, produces W bits per clock, and supports seed load, enable and error injection. A companion checker locks onto an incoming PRBS stream and counts bit errors. It sits between the Tiny Tapeout pin wrapper and the I/O pins, usable in loopback or chip-to-chip.

## Interface
- W, 8: bits generated/checked per clock; 1..32.
- CNT_W, 16: error counter width.
- LOCK_CNT, 4: consecutive good words needed to lock; must satisfy LOCK_CNT*W >= 32.
- UNLOCK_CNT, 4: consecutive errored words needed to drop lock.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-high.
- en  in  1  generator advance enable.
- mode  in  3  0=PRBS7 (x^7+x^6+1), 1=PRBS9 (x^9+x^5+1), 2=PRBS15 (x^15+x^14+1), 3=PRBS23 (x^23+x^18+1), 4=PRBS31 (x^31+x^28+1); 5..7 behave as 0.
- seed_load  in  1  load seed into generator state.
- seed  in  31  seed value; low n bits used.
- inj_err  in  1  error injection request (see Configuration).
- gen_data  out  W  generated word; bit 0 is the earliest bit.
- gen_valid  out  1  gen_data holds a new word.
- chk_data  in  W  received word; bit 0 is the earliest bit.
- chk_valid  in  1  chk_data is valid this cycle.
- err_clr  in  1  synchronous clear of err_cnt.
- locked  out  1  checker is in LOCKED.
- err_cnt  out  CNT_W  saturating bit-error count.

## Operation
- Generator state s is 31 bits; mode length n uses only s[n-1:0], with taps t1=n and t2 per the polynomial.
- Each bit step:
  - new = s[t1-1] ^ s[t2-1]
  - s = {s[n-2:0], new}
  - the output bit is new.
- W steps are chained per clock.
- Reset: s=1, mode_q=0, gen_data=0, gen_valid=0, checker in SEARCH, history=0, locked=0, err_cnt=0.
- Control priority, highest first:
  1. Mode change (mode != mode_q): s<=1, mode_q<=mode, gen_valid<=0, checker forced to SEARCH.
  2. seed_load: s<=seed masked to n bits, or 1 if the masked value is zero; gen_valid<=0.
  3. en: advance W bits, gen_data<=new bits, gen_valid<=1.
  4. Otherwise: gen_data holds, gen_valid<=0.
- Checker history register h (31 bits): for each valid received bit r, pred = h[t1-1]^h[t2-1], mismatch = r^pred, then h = {h[n-2:0], r}. This is self-synchronising.
- SEARCH state:
  - A valid word with zero mismatches and nonzero data increments the good counter; any other valid word clears it.
  - The good counter reaching LOCK_CNT moves the checker to LOCKED and clears the bad counter.
  - No error counting in SEARCH.
- LOCKED state:
  - err_cnt += popcount(mismatch) for each valid word, saturating at all-ones.
  - A word with any mismatch increments the bad counter; a clean word clears it.
  - The bad counter reaching UNLOCK_CNT moves the checker to SEARCH.
- A single received bit flip produces exactly 3 mismatches: at its own position and again at each tap.
- err_clr zeroes err_cnt; it takes priority over same-cycle counting, and that word's errors are discarded.

## Timing
- gen_data/gen_valid are registered and appear one cycle after en is sampled high.
- Checker has one-cycle latency: locked and err_cnt update at the edge that samples the chk_valid word.
- locked rises at the edge sampling the LOCK_CNT-th consecutive good word.
- Reset assertion clears all outputs immediately, mid-operation included. The first en edge after deassertion produces the first word.

## Configuration
- PRBS_ERR_INJ_EN defined: each cycle with inj_err=1 and a word produced, gen_data[0] is inverted. LFSR state is unaffected.
- Not defined: inj_err is ignored and the port is kept for pin compatibility.

## Test plan
- Reset, mode=0, W=8, en=1 -> first gen_data=0x60, gen_valid=1 one cycle later; after 127 words s returns to 1 and the sequence repeats.
- Loopback gen->chk for each mode 0..4 -> locked=1 within LOCK_CNT+1 valid words; err_cnt=0 after 1000 words.
- With PRBS_ERR_INJ_EN, one-cycle inj_err pulse while locked -> err_cnt=3, locked stays 1; without the macro -> err_cnt=0.
- seed_load with seed=0 -> s=1 and the stream restarts at 0x60; en=0 -> gen_data held, gen_valid=0.
- chk_data forced to 0xFF while locked, PRBS7, CNT_W=4 -> locked=0 after 4 words, err_cnt saturates at 15; err_clr -> 0.
- rst_n pulse mid-stream while locked -> locked=0 and err_cnt=0 immediately; relocks after deassertion.
